bitty_sequencer: RTL and testbench
==================================

BITTY_SEQUENCER -- requirements
Module: bitty_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and memory-address width.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, max wait cycles for mem_ack before fault.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle pulse; begins execution from pc=0 when IDLE.
REQ-006 stop  input  1  request to halt after the in-flight instruction retires.
REQ-007 mem_req  output  1  instruction-fetch request, held until acknowledged.
REQ-008 mem_addr  output  PC_W  fetch address, equals pc while mem_req=1.
REQ-009 mem_ack  input  1  fetch acknowledge; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  input  16  fetched instruction word.
REQ-011 instruction  output  16  registered fetched word, presented to the datapath.
REQ-012 en_i / en_s / en_c  output  1 each  datapath load strobes for instruction, source, and result registers.
REQ-013 en_reg  output  8  one-hot register-file write enable.
REQ-014 busy  output  1  high in every state except IDLE and FAULT.
REQ-015 fault  output  1  sticky; fetch timeout occurred.
REQ-016 retired  output  16  count of retired instructions.

Function
REQ-017 States: IDLE, FETCH, LOAD_I, EXEC_S, EXEC_C, WRITE, FAULT.
REQ-018 IDLE: start=1 -> pc<=0, FETCH; start ignored in all other states.
REQ-019 FETCH: mem_req=1; on mem_ack -> instruction<=mem_rdata, LOAD_I; if the wait count reaches ACK_TIMEOUT without ack -> FAULT.
REQ-020 LOAD_I: en_i=1 for exactly one cycle; then decode instruction[1:0] (format): 0 or 1 -> EXEC_S; 2 -> jump; 3 -> NOP.
REQ-021 EXEC_S: en_s=1 for one cycle -> EXEC_C.
REQ-022 EXEC_C: en_c=1 for one cycle -> WRITE.
REQ-023 WRITE: en_reg = one-hot of instruction[15:13] for one cycle; pc<=pc+1; retired++.
REQ-024 Jump (format 2): pc<=instruction[12:5] (truncated to PC_W); retired++; no en_s/en_c/en_reg.
REQ-025 NOP (format 3): pc<=pc+1; retired++; no datapath strobes.
REQ-026 After retire (WRITE, jump, NOP): stop seen since the last fetch -> IDLE; else -> FETCH.
REQ-027 Strobes mutually exclusive; at most one of en_i, en_s, en_c, or any en_reg bit high per cycle.
REQ-028 ALU instruction latency: ack cycle to en_reg pulse = 4 cycles.
REQ-029 pc wraps from 2^PC_W-1 to 0 silently; retired wraps at 16'hFFFF.
REQ-030 stop SHALL be latched; a stop during FETCH does not abort the fetch.
REQ-031 mem_ack outside FETCH ignored.
REQ-032 FAULT exit only by reset; all strobes 0; fault=1.

Reset
REQ-033 On reset: state=IDLE, pc=0, instruction=0, retired=0, fault=0, stop latch=0, all outputs 0.
REQ-034 Reset mid-instruction aborts immediately; no strobe is asserted in the cycle after reset deasserts.

Structure
REQ-035 A shared package bitty_pkg SHALL hold the state enum, format codes (FMT_REG=0, FMT_IMM=1, FMT_JMP=2, FMT_NOP=3), and instruction field-position constants.
REQ-036 One sub-module bitty_fetch SHALL own pc, mem_req, and the timeout counter; the FSM lives in bitty_sequencer.

Verification
REQ-037 Test 1: start, memory returns 16'h2000 (Rx=1, fmt 0) with 0-cycle ack -> en_i, en_s, en_c, en_reg=8'h02 on consecutive cycles; retired=1; pc=1.
REQ-038 Test 2: word at pc 0 = jump to 8'h40 (16'h0802) -> next mem_addr=8'h40; no en_s; retired=1.
REQ-039 Test 3: ack withheld for 15 cycles -> fault=1, busy=0; reset clears fault.
REQ-040 Test 4: stop asserted during EXEC_S -> WRITE completes, then IDLE; mem_req stays 0.
REQ-041 Test 5: pc=8'hFF with a NOP word -> next fetch address 8'h00.
REQ-042 Test 6: reset asserted during EXEC_C -> en_c and en_reg never pulse; pc=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty sequencer: FSM states, instruction formats
// and instruction field positions.
package bitty_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_I,
    S_EXEC_S,
    S_EXEC_C,
    S_WRITE,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    FMT_REG = 2'd0,
    FMT_IMM = 2'd1,
    FMT_JMP = 2'd2,
    FMT_NOP = 2'd3
  } fmt_t;

  localparam int INSTR_W = 16;
  localparam int FMT_LSB = 0;
  localparam int FMT_MSB = 1;
  localparam int JMP_LSB = 5;
  localparam int JMP_MSB = 12;
  localparam int RX_LSB  = 13;
  localparam int RX_MSB  = 15;

  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/bitty_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
interface bitty_sequencer_if #(parameter int PC_W = 8);

  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [15:0]     mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/bitty_fetch.sv
// Program counter, fetch request and acknowledge-timeout counter.
module bitty_fetch #(
  parameter int PC_W        = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetching,
  input  logic            pc_clear,
  input  logic            pc_inc,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_target,
  output logic            timeout,
  bitty_sequencer_if.master mem
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc <= '0;
    else if (pc_clear) pc <= '0;
    else if (pc_load)  pc <= pc_target;
    else if (pc_inc)   pc <= pc + PC_W'(1);
  end

  // wait_cnt equals the number of unacknowledged FETCH cycles already spent
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      wait_cnt <= '0;
    else if (!fetching || mem.mem_ack) wait_cnt <= '0;
    else                            wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout      = fetching && !mem.mem_ack && (wait_cnt == CNT_LAST);
  assign mem.mem_req  = fetching;
  assign mem.mem_addr = pc;

endmodule

// File: rtl/bitty_sequencer.sv
// Control sequencer: fetches 16-bit instructions and pulses the datapath load
// strobes in order; jumps and NOPs retire straight out of LOAD_I.
module bitty_sequencer
  import bitty_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  bitty_sequencer_if.master mem,
  output logic [15:0] instruction,
  output logic        en_i,
  output logic        en_s,
  output logic        en_c,
  output logic [7:0]  en_reg,
  output logic        busy,
  output logic        fault,
  output logic [15:0] retired
);

  state_t          state, state_nxt;
  fmt_t            fmt;
  logic            stop_q, timeout, fetching, retire;
  logic            pc_clear, pc_inc, pc_load;
  logic [PC_W-1:0] pc_target;

  assign fmt       = fmt_t'(instruction[FMT_MSB:FMT_LSB]);
  assign pc_target = PC_W'(instruction[JMP_MSB:JMP_LSB]);
  assign fetching  = (state == S_FETCH);
  assign busy      = (state != S_IDLE) && (state != S_FAULT);
  assign fault     = (state == S_FAULT);

  bitty_fetch #(.PC_W(PC_W), .ACK_TIMEOUT(ACK_TIMEOUT)) u_fetch (
    .clk(clk), .reset(reset), .fetching(fetching), .pc_clear(pc_clear),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
    .timeout(timeout), .mem(mem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en_i      = 1'b0;
    en_s      = 1'b0;
    en_c      = 1'b0;
    en_reg    = '0;
    pc_clear  = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE:   if (start) begin pc_clear = 1'b1; state_nxt = S_FETCH; end
      S_FETCH: begin
        if (mem.mem_ack)  state_nxt = S_LOAD_I;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_LOAD_I: begin
        en_i = 1'b1;
        case (fmt)
          FMT_JMP: begin pc_load = 1'b1; retire = 1'b1; end
          FMT_NOP: begin pc_inc  = 1'b1; retire = 1'b1; end
          default: state_nxt = S_EXEC_S;
        endcase
      end
      S_EXEC_S: begin en_s = 1'b1; state_nxt = S_EXEC_C; end
      S_EXEC_C: begin en_c = 1'b1; state_nxt = S_WRITE; end
      S_WRITE: begin
        en_reg = reg_onehot(instruction[RX_MSB:RX_LSB]);
        pc_inc = 1'b1;
        retire = 1'b1;
      end
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
    // a stop arriving in the retire cycle itself still counts
    if (retire) state_nxt = (stop_q || stop) ? S_IDLE : S_FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         instruction <= '0;
    else if (fetching && mem.mem_ack)  instruction <= mem.mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired <= '0;
    else if (retire) retired <= retired + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 stop_q <= 1'b0;
    else if (state == S_IDLE)  stop_q <= 1'b0;
    else if (stop)             stop_q <= 1'b1;
  end

endmodule

// File: tb/tb_bitty_sequencer.sv
// Bench for bitty_sequencer: directed scenarios plus randomized traffic checked
// every cycle against a latency-based behavioural model.
module tb_bitty_sequencer;

  localparam int PC_W        = 8;
  localparam int ACK_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [15:0] instruction, retired;
  logic        en_i, en_s, en_c, busy, fault;
  logic [7:0]  en_reg;

  bitty_sequencer_if #(.PC_W(PC_W)) bus ();

  bitty_sequencer #(.PC_W(PC_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mem(bus),
    .instruction(instruction), .en_i(en_i), .en_s(en_s), .en_c(en_c),
    .en_reg(en_reg), .busy(busy), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: an instruction is acked at cycle A; its strobes follow at A+1..A+4.
  logic [15:0] mem [256];
  int          cyc, fetch_start, ack_cyc, delay, force_delay, fault_age;
  bit          running, mfault, fetching, stop_flag;
  bit          k_start, k_stop, rand_mode;
  logic [15:0] word, last_instr, mret;
  logic [7:0]  mpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick_delay();
    if (force_delay >= 0) return force_delay;
    case ($urandom_range(0, 29))
      0:       return ACK_TIMEOUT - 1;
      1:       return ACK_TIMEOUT;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic model_reset();
    running = 0; mfault = 0; fetching = 0; stop_flag = 0;
    mpc = '0; mret = '0; last_instr = '0; word = '0; ack_cyc = -100; fault_age = 0;
  endtask

  task automatic step();
    logic [7:0]  x_reg;
    logic [1:0]  fmt;
    logic [15:0] rdata;
    bit          x_i, x_s, x_c, x_req, ack, ret;
    int          k;
    @(negedge clk);
    x_i = 0; x_s = 0; x_c = 0; x_reg = '0;
    fmt = word[1:0];
    if (running && !fetching) begin
      k   = cyc - ack_cyc;
      x_i = (k == 1);
      if (fmt < 2'd2) begin
        x_s = (k == 2);
        x_c = (k == 3);
        if (k == 4) x_reg = 8'(1 << word[15:13]);
      end
    end
    x_req = running && fetching;
    chk("en_i", 32'(en_i), 32'(x_i));
    chk("en_s", 32'(en_s), 32'(x_s));
    chk("en_c", 32'(en_c), 32'(x_c));
    chk("en_reg", 32'(en_reg), 32'(x_reg));
    chk("mem_req", 32'(bus.mem_req), 32'(x_req));
    if (x_req) chk("mem_addr", 32'(bus.mem_addr), 32'(mpc));
    chk("busy", 32'(busy), 32'(running));
    chk("fault", 32'(fault), 32'(mfault));
    chk("retired", 32'(retired), 32'(mret));
    chk("instruction", 32'(instruction), 32'(last_instr));

    start = k_start || (rand_mode && $urandom_range(0, 5) == 0);
    stop  = k_stop  || (rand_mode && $urandom_range(0, 24) == 0);
    ack   = x_req && (cyc - fetch_start == delay);
    rdata = ack ? mem[mpc] : 16'($urandom);
    bus.mem_ack   = ack || (!x_req && rand_mode && $urandom_range(0, 3) == 0);
    bus.mem_rdata = rdata;

    if (running) begin
      if (stop) stop_flag = 1;
      if (fetching) begin
        if (ack) begin
          fetching = 0; ack_cyc = cyc; word = mem[mpc]; last_instr = word;
        end else if (cyc - fetch_start == ACK_TIMEOUT - 1) begin
          running = 0; mfault = 1;
        end
      end else begin
        k   = cyc - ack_cyc;
        ret = (fmt >= 2'd2 && k == 1) || (fmt < 2'd2 && k == 4);
        if (ret) begin
          mret = mret + 16'd1;
          mpc  = (fmt == 2'd2) ? word[12:5] : mpc + 8'd1;
          if (stop_flag) running = 0;
          else begin fetching = 1; fetch_start = cyc + 1; delay = pick_delay(); end
        end
      end
    end else if (!mfault && start) begin
      running = 1; fetching = 1; fetch_start = cyc + 1; mpc = '0;
      stop_flag = 0; delay = pick_delay();
    end
    cyc++;
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("rst_en_i", 32'(en_i), 0);
    chk("rst_en_s", 32'(en_s), 0);
    chk("rst_en_c", 32'(en_c), 0);
    chk("rst_en_reg", 32'(en_reg), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_instruction", 32'(instruction), 0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic go();
    k_start = 1; step(); k_start = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    k_start = 0; k_stop = 0; rand_mode = 0; force_delay = 0; cyc = 0; fetch_start = 0; delay = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0003;
    model_reset();
    repeat (2) @(posedge clk);
    apply_reset();

    // ALU instruction with immediate ack, then a NOP whose fetch sees stop
    mem[0] = 16'h2000; mem[1] = 16'h0003;
    go();
    step(); chk("t1_req", 32'(bus.mem_req), 1); chk("t1_addr", 32'(bus.mem_addr), 0);
    step(); chk("t1_en_i", 32'(en_i), 1);
    step(); chk("t1_en_s", 32'(en_s), 1);
    step(); chk("t1_en_c", 32'(en_c), 1);
    step(); chk("t1_en_reg", 32'(en_reg), 'h02);
    k_stop = 1; step(); k_stop = 0;
    chk("t1_retired", 32'(retired), 1); chk("t1_pc", 32'(bus.mem_addr), 1);
    step(); chk("t1_stop_fetch_instr", 32'(instruction), 'h0003);
    step(); chk("t1_idle", 32'(busy), 0); chk("t1_retired2", 32'(retired), 2);

    // stop during EXEC_S: WRITE still completes, then idle
    apply_reset();
    go(); step(); step();
    k_stop = 1; step(); k_stop = 0; chk("t4_en_s", 32'(en_s), 1);
    step(); chk("t4_en_c", 32'(en_c), 1);
    step(); chk("t4_en_reg", 32'(en_reg), 'h02);
    step(); chk("t4_busy", 32'(busy), 0); chk("t4_req", 32'(bus.mem_req), 0);
    step(); chk("t4_req2", 32'(bus.mem_req), 0);

    // jump to 8'h40
    apply_reset();
    mem[0] = 16'h0802; mem[8'h40] = 16'h0003;
    go(); step();
    step(); chk("t2_en_i", 32'(en_i), 1);
    k_stop = 1; step(); k_stop = 0;
    chk("t2_no_en_s", 32'(en_s), 0); chk("t2_addr", 32'(bus.mem_addr), 'h40);
    chk("t2_req", 32'(bus.mem_req), 1); chk("t2_retired", 32'(retired), 1);
    step(); step(); chk("t2_idle", 32'(busy), 0);

    // pc wrap: jump to 8'hFF, NOP there, next fetch is address 0
    apply_reset();
    mem[0] = 16'h1FE2; mem[8'hFF] = 16'h0003;
    go(); step(); step();
    step(); chk("t5_addr_ff", 32'(bus.mem_addr), 'hFF);
    step();
    k_stop = 1; step(); k_stop = 0;
    chk("t5_wrap_req", 32'(bus.mem_req), 1); chk("t5_wrap_addr", 32'(bus.mem_addr), 0);
    step(); step(); chk("t5_idle", 32'(busy), 0);

    // ack on the last allowed cycle is accepted
    apply_reset();
    mem[0] = 16'h2000; force_delay = ACK_TIMEOUT - 1;
    go(); repeat (ACK_TIMEOUT) step();
    step(); chk("t3_late_ack_en_i", 32'(en_i), 1); chk("t3_late_ack_fault", 32'(fault), 0);

    // ack withheld: fault after ACK_TIMEOUT cycles, cleared by reset
    apply_reset();
    force_delay = 1000;
    go(); repeat (ACK_TIMEOUT) step();
    chk("t3_prefault", 32'(fault), 0); chk("t3_prefault_req", 32'(bus.mem_req), 1);
    step(); chk("t3_fault", 32'(fault), 1); chk("t3_busy", 32'(busy), 0);
    chk("t3_req", 32'(bus.mem_req), 0);
    k_start = 1; step(); k_start = 0;
    step(); chk("t3_sticky", 32'(fault), 1);
    apply_reset();
    step(); chk("t3_cleared", 32'(fault), 0);

    // reset just after entering EXEC_C aborts the instruction
    force_delay = 0; mem[0] = 16'h2000;
    go(); step(); step();
    step(); chk("t6_en_s", 32'(en_s), 1);
    @(posedge clk); #1;
    apply_reset();
    step(); chk("t6_no_en_reg", 32'(en_reg), 0); chk("t6_no_en_c", 32'(en_c), 0);
    step();

    // randomized traffic
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    force_delay = -1; rand_mode = 1;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (mfault) fault_age++;
      if (fault_age > 3 || $urandom_range(0, 499) == 0) apply_reset();
    end
    rand_mode = 0;
    apply_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
